// File: rtl/fir_coef_bank.sv
// Runtime-writable multi-bank coefficient store for the tap-serial FIR MAC.
// Inactive banks are host-loaded; the active bank only changes at a frame boundary.
module fir_coef_bank #(
    parameter int COEF_W   = 16,
    parameter int NTAPS    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SETS = 4,
    parameter int SET_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     frame_start,
    output logic signed [COEF_W-1:0] rd_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [SET_W-1:0]         wr_set,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     sel_req,
    input  logic [SET_W-1:0]         sel_set,
    output logic [SET_W-1:0]         active_set,
    output logic                     swap_pending,
    output logic                     busy
);

    localparam int DEPTH = NUM_SETS * NTAPS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [IDX_W-1:0]         clr_idx;
    logic                     clr_last;
    logic [SET_W-1:0]         pending_set;
    logic [SET_W-1:0]         eff_set;
    logic                     run;
    logic                     wr_fire;
    logic                     wr_in_range;
    logic                     rd_in_range;
    logic                     sel_valid;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         rd_idx;
    logic signed [COEF_W-1:0] mem [DEPTH];

    function automatic logic [IDX_W-1:0] flat_idx(input logic [SET_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return IDX_W'(s) * IDX_W'(NTAPS) + IDX_W'(a);
    endfunction

    assign run      = (state == S_RUN);
    assign busy     = (state == S_CLEAR);
    assign clr_last = (clr_idx == IDX_W'(DEPTH - 1));

    // The read that coincides with the swap must already see the incoming bank.
    assign eff_set     = (swap_pending && frame_start) ? pending_set : active_set;
    assign rd_in_range = (32'(rd_addr) < NTAPS);
    assign rd_idx      = flat_idx(eff_set, rd_addr);

    // Out-of-range writes are handshaked normally but never reach the array.
    assign wr_ready    = run && (wr_set != active_set);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (32'(wr_set) < NUM_SETS) && (32'(wr_addr) < NTAPS);
    assign wr_idx      = flat_idx(wr_set, wr_addr);
    assign sel_valid   = sel_req && (32'(sel_set) < NUM_SETS);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: next-state is defaulted first so no path leaves it unassigned and infers a latch.
        state_next = state;
        case (state)
            S_CLEAR: if (clr_last) state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (busy) begin
            clr_idx <= clr_last ? '0 : clr_idx + IDX_W'(1);
        end
    end

    // NOTE: the array has no reset term so it maps onto RAM; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_idx] <= '0;
            end else if (wr_fire && wr_in_range) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (run && rd_in_range) ? mem[rd_idx] : '0;
        end
    end

    // A request arriving with frame_start is latched after the older one is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_set   <= '0;
            pending_set  <= '0;
            swap_pending <= 1'b0;
        end else if (run) begin
            if (swap_pending && frame_start) begin
                active_set   <= pending_set;
                swap_pending <= 1'b0;
            end
            if (sel_valid) begin
                pending_set  <= sel_set;
                swap_pending <= 1'b1;
            end
        end
    end

endmodule
